// File: rtl/cpu_pkg.sv
// Shared CPU definitions: jump opcodes (shared with the watchdog and control
// unit), interrupt source indices and the interrupt controller state encoding.
package cpu_pkg;

  localparam logic [5:0] JR  = 6'b010010;
  localparam logic [5:0] JF  = 6'b010101;
  localparam logic [5:0] J   = 6'b111100;
  localparam logic [5:0] JTM = 6'b111101;
  localparam logic [5:0] JAL = 6'b111110;

  localparam int IRQ_WDOG = 0;
  localparam int IRQ_IO0  = 1;
  localparam int IRQ_IO1  = 2;
  localparam int IRQ_IO2  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ISR  = 2'd2
  } irq_state_t;

  // True for any control-transfer opcode; a jump in flight is never preempted.
  function automatic logic is_jump(input logic [5:0] op);
    return (op == JR) || (op == JF) || (op == J) || (op == JTM) || (op == JAL);
  endfunction

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 (watchdog) has the highest priority.
module prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// CPU interrupt controller: edge-latches request lines, waits for a safe
// preemption point (user mode, no jump executing), handshakes with the control
// unit, records return PC and cause, and holds until return-from-interrupt.
//
//   state   | meaning
//   IDLE    | no service in progress; accept lowest pending irq when safe
//   REQ     | int_req raised, waiting for control unit int_ack
//   ISR     | handler running, waiting for reti
module interrupt_controller
  import cpu_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int PC_WIDTH = 32,
  parameter int CAUSE_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                isUser,
  input  logic [5:0]          opcode,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [NUM_SRC-1:0]  irq_src,
  input  logic                int_ack,
  input  logic                reti,
  output logic                int_req,
  output logic [CAUSE_W-1:0]  int_cause,
  output logic [PC_WIDTH-1:0] epc,
  output logic                in_isr
);

  irq_state_t          state, state_nxt;
  logic [NUM_SRC-1:0]  irq_src_q;
  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  clr;
  logic [CAUSE_W-1:0]  sel_idx;
  logic                sel_valid;
  logic                safe;
  logic                accept;

  prio_enc #(
    .NUM_SRC(NUM_SRC),
    .IDX_W  (CAUSE_W)
  ) u_prio_enc (
    .req  (pending),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

  assign rise   = irq_src & ~irq_src_q;
  assign safe   = isUser & ~is_jump(opcode);
  assign accept = (state == ST_IDLE) & sel_valid & safe;
  assign clr    = accept ? (NUM_SRC'(1) << sel_idx) : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Edge detect and pending latch; a fresh edge wins over the acceptance clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_src_q <= '0;
      pending   <= '0;
    end else begin
      irq_src_q <= irq_src;
      pending   <= (pending & ~clr) | rise;
    end
  end

  // Capture return address and cause at acceptance; held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc       <= '0;
      int_cause <= '0;
    end else if (accept) begin
      epc       <= pc;
      int_cause <= sel_idx;
    end
  end

  // Next-state logic; stray int_ack outside REQ and reti outside ISR are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)  state_nxt = ST_REQ;
      ST_REQ:  if (int_ack) state_nxt = ST_ISR;
      ST_ISR:  if (reti)    state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  assign int_req = (state == ST_REQ);
  assign in_isr  = (state == ST_ISR);

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a behavioural
// model of the service protocol.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        isUser = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] pc = 32'd0;
  logic [3:0]  irq_src = 4'd0;
  logic        int_ack = 1'b0;
  logic        reti = 1'b0;
  logic        int_req;
  logic [1:0]  int_cause;
  logic [31:0] epc;
  logic        in_isr;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  interrupt_controller #(.NUM_SRC(4), .PC_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .isUser   (isUser),
    .opcode   (opcode),
    .pc       (pc),
    .irq_src  (irq_src),
    .int_ack  (int_ack),
    .reti     (reti),
    .int_req  (int_req),
    .int_cause(int_cause),
    .epc      (epc),
    .in_isr   (in_isr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit        m_prev [4];
  bit        m_pend [4];
  bit        m_waiting_ack = 0;
  bit        m_in_handler  = 0;
  int        m_cause = 0;
  bit [31:0] m_epc = 0;

  function automatic bit is_jump_op(input logic [5:0] op);
    return op == 6'b010010 || op == 6'b010101 || op == 6'b111100 ||
           op == 6'b111101 || op == 6'b111110;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = 0;
        m_pend[i] = 0;
      end
      m_waiting_ack = 0;
      m_in_handler  = 0;
      m_cause       = 0;
      m_epc         = 0;
    end else begin
      bit rises [4];
      for (int i = 0; i < 4; i++) begin
        rises[i]  = irq_src[i] && !m_prev[i];
        m_prev[i] = irq_src[i];
      end
      if (m_waiting_ack) begin
        if (int_ack) begin
          m_waiting_ack = 0;
          m_in_handler  = 1;
        end
      end else if (m_in_handler) begin
        if (reti) m_in_handler = 0;
      end else if (isUser && !is_jump_op(opcode)) begin
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i] && !m_waiting_ack) begin
            m_waiting_ack = 1;
            m_cause       = i;
            m_epc         = pc;
            m_pend[i]     = 0;
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (rises[i]) m_pend[i] = 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model int_req",   {31'd0, int_req},   {31'd0, m_waiting_ack});
      chk("model in_isr",    {31'd0, in_isr},    {31'd0, m_in_handler});
      chk("model int_cause", {30'd0, int_cause}, 32'(m_cause));
      chk("model epc",       epc,                m_epc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    irq_src = 4'd0;
    int_ack = 1'b0;
    reti    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    chk("reset int_req", {31'd0, int_req}, 32'd0);
    chk("reset in_isr", {31'd0, in_isr}, 32'd0);

    // Basic service
    isUser = 1'b1; opcode = 6'b000000; pc = 32'h100;
    irq_src = 4'b0001;
    tick();
    chk("basic req latency-1", {31'd0, int_req}, 32'd0);
    tick();
    chk("basic int_req", {31'd0, int_req}, 32'd1);
    chk("basic epc", epc, 32'h100);
    chk("basic cause", {30'd0, int_cause}, 32'd0);
    pc = 32'h200;
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("basic in_isr", {31'd0, in_isr}, 32'd1);
    chk("basic req dropped", {31'd0, int_req}, 32'd0);
    chk("basic epc frozen", epc, 32'h100);
    repeat (4) tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("basic back idle", {31'd0, in_isr}, 32'd0);
    tick();
    chk("basic level no re-req", {31'd0, int_req}, 32'd0);
    chk("basic epc kept", epc, 32'h100);
    irq_src = 4'd0;
    tick();

    // Jump block then kernel block
    pc = 32'h300; opcode = 6'b111110; irq_src = 4'b0010;
    tick();
    irq_src = 4'd0;
    repeat (3) begin
      tick();
      chk("jal blocks", {31'd0, int_req}, 32'd0);
    end
    opcode = 6'b000000;
    tick();
    chk("after jump req", {31'd0, int_req}, 32'd1);
    chk("after jump cause", {30'd0, int_cause}, 32'd1);
    chk("after jump epc", epc, 32'h300);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    isUser = 1'b0; irq_src = 4'b1000;
    tick();
    irq_src = 4'd0;
    repeat (10) begin
      tick();
      chk("kernel never taken", {31'd0, int_req}, 32'd0);
    end

    // Reset discards pending; mid-ISR reset clears outputs at once
    isUser = 1'b1;
    do_reset();
    repeat (5) begin
      tick();
      chk("pending discarded", {31'd0, int_req}, 32'd0);
    end
    pc = 32'h440; irq_src = 4'b0001;
    tick(); tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("pre-reset in_isr", {31'd0, in_isr}, 32'd1);
    irq_src = 4'd0;
    reset = 1'b0;
    #1;
    chk("async rst in_isr", {31'd0, in_isr}, 32'd0);
    chk("async rst int_req", {31'd0, int_req}, 32'd0);
    chk("async rst epc", epc, 32'd0);
    chk("async rst cause", {30'd0, int_cause}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (5) begin
      tick();
      chk("no req after reset", {31'd0, int_req}, 32'd0);
    end

    // Priority and queueing
    pc = 32'h500; irq_src = 4'b0110;
    tick();
    irq_src = 4'd0;
    tick();
    chk("prio first cause", {30'd0, int_cause}, 32'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick();
    reti = 1'b1; tick(); reti = 1'b0;
    chk("no take in reti+1 out", {31'd0, int_req}, 32'd0);
    tick();
    chk("prio second req", {31'd0, int_req}, 32'd1);
    chk("prio second cause", {30'd0, int_cause}, 32'd2);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;

    // Level hold with a new edge during the handler
    begin
      int services = 0;
      bit last_req = 0;
      irq_src = 4'b0001;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (int_req && !last_req) services++;
        last_req = int_req;
        int_ack = int_req;
        reti = in_isr && (c % 5 == 0);
        if (c == 10) irq_src = 4'b0101;
      end
      int_ack = 1'b0; reti = 1'b0;
      chk("level hold services", 32'(services), 32'd2);
    end
    irq_src = 4'd0;
    tick(); tick();

    // Stray strobes and set/clear collision
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("stray ack idle", {31'd0, int_req | in_isr}, 32'd0);
    irq_src = 4'b0010; tick(); irq_src = 4'd0; tick();
    reti = 1'b1; tick(); reti = 1'b0;
    chk("stray reti in req", {31'd0, int_req}, 32'd1);
    int_ack = 1'b1; tick();
    tick(); int_ack = 1'b0;
    chk("stray ack in isr", {31'd0, in_isr}, 32'd1);
    reti = 1'b1; tick(); reti = 1'b0;
    opcode = 6'b010010; irq_src = 4'b0010;
    tick();
    irq_src = 4'd0;
    tick();
    opcode = 6'b000000; irq_src = 4'b0010;
    tick();
    chk("collision accepted", {31'd0, int_req}, 32'd1);
    irq_src = 4'd0; int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    chk("collision re-req", {31'd0, int_req}, 32'd1);
    chk("collision cause", {30'd0, int_cause}, 32'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      isUser = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 9))
        0: opcode = 6'b010010;
        1: opcode = 6'b010101;
        2: opcode = 6'b111100;
        3: opcode = 6'b111101;
        4: opcode = 6'b111110;
        default: opcode = 6'($urandom);
      endcase
      pc = $urandom;
      int_ack = int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      reti = in_isr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
